// File: rtl/agu_bank_resp.sv
// Four-bank memory responder for the AGU address channels A..D: per-bank arbitration,
// 16/32-bit reads and writes, registered read return. Optional round-robin arbitration via AGU_BANK_RR_EN.
module agu_bank_resp #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [3:0]                    req,
  input  logic [3:0]                    we,
  input  logic [3:0]                    wide,
  input  logic [4*(ADDR_WIDTH+2)-1:0]   addr,
  input  logic [127:0]                  wdata,
  input  logic                          stall_clr,
  output logic [3:0]                    gnt,
  output logic [3:0]                    rvalid,
  output logic [127:0]                  rdata,
  output logic [15:0]                   stall_cnt
);

  localparam int unsigned AW2   = ADDR_WIDTH + 2;
  localparam int unsigned WW    = ADDR_WIDTH - 1;
  localparam int unsigned DEPTH = 1 << WW;

  logic [1:0]    ch_bank [4];
  logic [WW-1:0] ch_word [4];
  logic [3:0]    ch_lane;

  logic [3:0]    bank_hit;
  logic [1:0]    bank_ch   [4];
  logic [1:0]    prio_base [4];
  logic [1:0]    cand;

  logic [127:0]  bank_q_data;

  logic [3:0]    rvalid_q;
  logic [3:0]    wide_q;
  logic [3:0]    lane_q;
  logic [1:0]    bank_q  [4];
  logic [31:0]   hold_q  [4];
  logic [31:0]   bw      [4];
  logic [31:0]   rd_word [4];

  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      ch_bank[c] = addr[c*AW2 + ADDR_WIDTH +: 2];
      ch_word[c] = addr[c*AW2 + 1 +: WW];
      ch_lane[c] = addr[c*AW2];
    end
  end

`ifdef AGU_BANK_RR_EN
  logic [1:0] rr_ptr [4];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned b = 0; b < 4; b++) rr_ptr[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++)
        if (bank_hit[b]) rr_ptr[b] <= bank_ch[b] + 2'd1;
    end
  end

  always_comb prio_base = rr_ptr;
`else
  always_comb begin
    for (int unsigned b = 0; b < 4; b++) prio_base[b] = '0;
  end
`endif

  // Scan channels starting at the bank's priority base; first requester of that bank wins.
  always_comb begin
    gnt      = '0;
    bank_hit = '0;
    cand     = '0;
    for (int unsigned b = 0; b < 4; b++) bank_ch[b] = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        cand = prio_base[b] + k[1:0];
        if (!bank_hit[b] && req[cand] && (ch_bank[cand] == b[1:0])) begin
          bank_hit[b]   = 1'b1;
          bank_ch[b]    = cand;
          gnt[cand]     = 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [15:0]   mem_lo [DEPTH];
    logic [15:0]   mem_hi [DEPTH];
    logic [15:0]   rd_lo_q;
    logic [15:0]   rd_hi_q;
    logic [1:0]    sel;
    logic [WW-1:0] word;
    logic          wr_lo;
    logic          wr_hi;
    logic          rd;
    logic [15:0]   wd_lo;
    logic [15:0]   wd_hi;

    always_comb begin
      sel   = bank_ch[b];
      word  = ch_word[sel];
      wr_lo = bank_hit[b] & we[sel] & (wide[sel] | ~ch_lane[sel]);
      wr_hi = bank_hit[b] & we[sel] & (wide[sel] | ch_lane[sel]);
      rd    = bank_hit[b] & ~we[sel];
      wd_lo = wdata[32*sel +: 16];
      wd_hi = wide[sel] ? wdata[32*sel + 16 +: 16] : wdata[32*sel +: 16];
    end

    always_ff @(posedge clk) begin
      if (wr_lo) mem_lo[word] <= wd_lo;
      if (wr_hi) mem_hi[word] <= wd_hi;
      if (rd) begin
        rd_lo_q <= mem_lo[word];
        rd_hi_q <= mem_hi[word];
      end
    end

    assign bank_q_data[32*b +: 32] = {rd_hi_q, rd_lo_q};
  end

  // Bank output is live only in the cycle after the read; a per-channel copy holds it afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= '0;
      wide_q   <= '0;
      lane_q   <= '0;
      for (int unsigned c = 0; c < 4; c++) begin
        bank_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      rvalid_q <= gnt & ~we;
      for (int unsigned c = 0; c < 4; c++) begin
        if (gnt[c] && !we[c]) begin
          bank_q[c] <= ch_bank[c];
          wide_q[c] <= wide[c];
          lane_q[c] <= ch_lane[c];
        end
        if (rvalid_q[c]) hold_q[c] <= rd_word[c];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      bw[c]      = bank_q_data[32*bank_q[c] +: 32];
      rd_word[c] = wide_q[c] ? bw[c] : {16'h0, (lane_q[c] ? bw[c][31:16] : bw[c][15:0])};
      rdata[32*c +: 32] = rvalid_q[c] ? rd_word[c] : hold_q[c];
    end
  end

  assign rvalid = rvalid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (|(req & ~gnt) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_agu_bank_resp.sv
// Randomized self-checking bench for agu_bank_resp against a behavioural bank/arbiter model.
module tb_agu_bank_resp;
  localparam int unsigned AW  = 4;
  localparam int unsigned AW2 = AW + 2;
  localparam int unsigned NW  = 1 << (AW - 1);

  logic           clk = 1'b0;
  logic           rstn;
  logic [3:0]     req, we, wide;
  logic [4*AW2-1:0] addr;
  logic [127:0]   wdata;
  logic           stall_clr;
  logic [3:0]     gnt, rvalid;
  logic [127:0]   rdata;
  logic [15:0]    stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] mmem [4][NW];
  logic [31:0] exp_rdata [4];
  logic [3:0]  exp_rvalid;
  logic [3:0]  last_gnt;
  logic [15:0] exp_stall;
  int          mptr [4];

  agu_bank_resp #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .wide(wide), .addr(addr),
    .wdata(wdata), .stall_clr(stall_clr), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_ch(input int c, input logic r, input logic w, input logic wd,
                        input logic [AW2-1:0] a, input logic [31:0] d);
    req[c] = r; we[c] = w; wide[c] = wd;
    addr[c*AW2 +: AW2] = a;
    wdata[c*32 +: 32]  = d;
  endtask

  // Winner per bank: requester closest (cyclically) at or after the bank's priority pointer.
  task automatic model_arb(output logic [3:0] g);
    logic [AW2-1:0] a;
    int best, bestd, d;
    g = '0;
    for (int b = 0; b < 4; b++) begin
      best = -1; bestd = 4;
      for (int c = 0; c < 4; c++) begin
        a = addr[c*AW2 +: AW2];
        d = (c - mptr[b] + 4) % 4;
        if (req[c] && (int'(a[AW2-1:AW]) == b) && d < bestd) begin
          bestd = d; best = c;
        end
      end
      if (best >= 0) begin
        g[best] = 1'b1;
`ifdef AGU_BANK_RR_EN
        mptr[b] = (best + 1) % 4;
`endif
      end
    end
  endtask

  task automatic do_cycle();
    logic [3:0] g;
    logic [AW2-1:0] a;
    logic [31:0] w;
    int bk, wd;
    #1;
    model_arb(g);
    check_val("gnt", gnt, g);
    for (int c = 0; c < 4; c++) begin
      a = addr[c*AW2 +: AW2];
      bk = int'(a[AW2-1:AW]);
      wd = int'(a[AW-1:1]);
      exp_rvalid[c] = 1'b0;
      if (g[c]) begin
        w = mmem[bk][wd];
        if (we[c]) begin
          if (wide[c]) w = wdata[c*32 +: 32];
          else if (a[0]) w[31:16] = wdata[c*32 +: 16];
          else w[15:0] = wdata[c*32 +: 16];
          mmem[bk][wd] = w;
        end else begin
          exp_rvalid[c] = 1'b1;
          exp_rdata[c]  = wide[c] ? w : (a[0] ? {16'h0, w[31:16]} : {16'h0, w[15:0]});
        end
      end
    end
    if (stall_clr) exp_stall = '0;
    else if ((req & ~g) != 4'h0 && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    last_gnt = g;
    @(posedge clk); #1;
    check_val("rvalid", rvalid, exp_rvalid);
    for (int c = 0; c < 4; c++) check_val("rdata", rdata[c*32 +: 32], exp_rdata[c]);
    check_val("stall_cnt", stall_cnt, exp_stall);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = '0; stall_clr = 1'b0;
    #2;
    check_val("rst_rvalid", rvalid, 4'h0);
    for (int c = 0; c < 4; c++) check_val("rst_rdata", rdata[c*32 +: 32], 32'h0);
    check_val("rst_stall", stall_cnt, 16'h0);
    set_ch(0, 1'b1, 1'b0, 1'b1, 6'h00, 32'h0);
    set_ch(1, 1'b1, 1'b0, 1'b1, 6'h02, 32'h0);
    #1;
    check_val("rst_gnt", gnt, 4'b0001);
    @(posedge clk); #1;
    check_val("rst_stall_hold", stall_cnt, 16'h0);
    check_val("rst_rvalid_hold", rvalid, 4'h0);
    req = '0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin exp_rdata[c] = '0; mptr[c] = 0; end
    exp_rvalid = '0; exp_stall = '0; last_gnt = '0;
  endtask

  initial begin
    rstn = 1'b1; req = '0; we = '0; wide = '0; addr = '0; wdata = '0; stall_clr = 1'b0;
    #1;
    do_reset();

    // Fill every word: channel c writes bank c, so all four are granted together.
    for (int w = 0; w < int'(NW); w++) begin
      for (int c = 0; c < 4; c++)
        set_ch(c, 1'b1, 1'b1, 1'b1, {c[1:0], w[AW-2:0], 1'b0}, $urandom);
      do_cycle();
    end
    req = '0;

    set_ch(0, 1'b1, 1'b1, 1'b1, 6'h04, 32'hDEADBEEF); do_cycle();
    set_ch(0, 1'b1, 1'b1, 1'b1, 6'h06, 32'hDEADBEEF); do_cycle();
    req = '0;
    set_ch(1, 1'b1, 1'b0, 1'b0, 6'h04, 32'h0); do_cycle();
    check_val("b_rd_lo", rdata[63:32], 32'h0000BEEF);
    check_val("b_rv_lo", rvalid[1], 1'b1);
    set_ch(1, 1'b1, 1'b0, 1'b0, 6'h05, 32'h0); do_cycle();
    check_val("b_rd_hi", rdata[63:32], 32'h0000DEAD);
    req = '0;
    set_ch(2, 1'b1, 1'b1, 1'b0, 6'h07, 32'h00001234); do_cycle();
    req = '0;
    set_ch(3, 1'b1, 1'b0, 1'b1, 6'h06, 32'h0); do_cycle();
    check_val("d_rd_wide", rdata[127:96], 32'h1234BEEF);
    req = '0; do_cycle();
    check_val("d_rv_pulse", rvalid[3], 1'b0);
    check_val("d_rd_hold", rdata[127:96], 32'h1234BEEF);

    do_reset();
    set_ch(0, 1'b1, 1'b0, 1'b1, 6'h10, 32'h0);
    set_ch(1, 1'b1, 1'b0, 1'b1, 6'h12, 32'h0);
    set_ch(2, 1'b1, 1'b0, 1'b1, 6'h20, 32'h0);
    set_ch(3, 1'b1, 1'b0, 1'b1, 6'h30, 32'h0);
    #1; check_val("conf_g1", gnt, 4'b1101);
    do_cycle();
    req[0] = 1'b0;
    #1; check_val("conf_g2", gnt, 4'b1110);
    do_cycle();
    check_val("conf_stall", stall_cnt, 16'd1);
    req = '0; do_cycle();

`ifdef AGU_BANK_RR_EN
    do_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 1'b0, 1'b1, {2'b00, c[1:0], 2'b00}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1; check_val("rr_order", gnt, 4'b0001 << (i % 4));
      do_cycle();
    end
    req = '0; do_cycle();
`endif

    for (int n = 0; n < 400; n++) begin
      stall_clr = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < 4; c++) begin
        if (req[c] && !last_gnt[c]) begin
          if ($urandom_range(0, 7) == 0) req[c] = 1'b0;
        end else begin
          set_ch(c, ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 6'($urandom), $urandom);
        end
      end
      do_cycle();
    end
    req = '0; stall_clr = 1'b0;

    // Saturation: A and B fight over bank 0 every cycle.
    set_ch(0, 1'b1, 1'b0, 1'b1, 6'h00, 32'h0);
    set_ch(1, 1'b1, 1'b0, 1'b1, 6'h02, 32'h0);
    stall_clr = 1'b1;
    @(posedge clk); #1; check_val("sat_clr_prio", stall_cnt, 16'h0);
    stall_clr = 1'b0;
    repeat (65534) @(posedge clk);
    #1; check_val("sat_fffe", stall_cnt, 16'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1; check_val("sat_ffff", stall_cnt, 16'hFFFF);
    stall_clr = 1'b1;
    @(posedge clk); #1; check_val("sat_clr", stall_cnt, 16'h0);
    stall_clr = 1'b0;
    @(posedge clk); #1; check_val("sat_restart", stall_cnt, 16'h1);
    req = '0;
    do_reset();

    set_ch(0, 1'b1, 1'b0, 1'b1, 6'h06, 32'h0); do_cycle();
    rstn = 1'b0; req = '0;
    #1;
    check_val("midrst_rvalid", rvalid, 4'h0);
    check_val("midrst_rdata", rdata[31:0], 32'h0);
    @(posedge clk); #1;
    check_val("midrst_rvalid2", rvalid, 4'h0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
